// File: rtl/cr_structs.sv
// Shared TLV definitions used by the parser-side user stages.
//   tlv_types_e    : TLV type codes carried in typen
//   tlvp_if_bus_t  : one TLV word as seen on the parser usr_ib/usr_ob FIFO ports
//   BYTECNT_W_MAX  : widest byte counter any user stage may instantiate
package cr_structs;

    localparam int BYTECNT_W_MAX = 32;

    typedef enum logic [7:0] {
        RQE      = 8'd0,
        CMD      = 8'd1,
        FRMD     = 8'd2,
        PHD      = 8'd3,
        PFD      = 8'd4,
        DATA_UNK = 8'd5,
        DATA     = 8'd6,
        CQE      = 8'd7,
        FTR      = 8'd8,
        LZ77     = 8'd9,
        STAT     = 8'd10
    } tlv_types_e;

    typedef struct packed {
        logic        insert;
        logic [7:0]  ordern;
        tlv_types_e  typen;
        logic        sot;
        logic        eot;
        logic        tlast;
        logic [7:0]  tid;
        logic [7:0]  tstrb;
        logic [7:0]  tuser;
        logic [63:0] tdata;
    } tlvp_if_bus_t;

endpackage

// File: rtl/cr_tlvp_usr_bytecnt_pkg.sv
// Block-local constants for cr_tlvp_usr_bytecnt.
//   CNT_W_DEF / FTR_CNT_LSB_DEF : default counter width and footer field position
//   bytecnt_params_ok()         : legality of a (width, lsb) pair for the footer patch
package cr_tlvp_usr_bytecnt_pkg;

    localparam int CNT_W_DEF       = 24;
    localparam int FTR_CNT_LSB_DEF = 0;

    // The count field must sit entirely inside tdata[63:0].
    function automatic bit bytecnt_params_ok(input int cnt_w, input int lsb);
        return (cnt_w >= 1) && (cnt_w <= cr_structs::BYTECNT_W_MAX) &&
               (lsb >= 0) && (lsb + cnt_w <= 64);
    endfunction

endpackage

// File: rtl/cr_tlvp_usr_bytecnt_if.sv
// Parser user-side FIFO ports (inbound pop side + outbound push side).
//   master : the parser FIFOs (drive empty/full/head word, observe rd/wr/out word)
//   slave  : the user stage (pops inbound, pushes outbound)
interface cr_tlvp_usr_bytecnt_if;

    logic                     usr_ib_empty;
    logic                     usr_ib_aempty;
    cr_structs::tlvp_if_bus_t usr_ib_tlv;
    logic                     usr_ib_rd;
    logic                     usr_ob_full;
    logic                     usr_ob_afull;
    logic                     usr_ob_wr;
    cr_structs::tlvp_if_bus_t usr_ob_tlv;

    modport master (
        output usr_ib_empty, usr_ib_aempty, usr_ib_tlv,
        input  usr_ib_rd,
        output usr_ob_full, usr_ob_afull,
        input  usr_ob_wr, usr_ob_tlv
    );

    modport slave (
        input  usr_ib_empty, usr_ib_aempty, usr_ib_tlv,
        output usr_ib_rd,
        input  usr_ob_full, usr_ob_afull,
        output usr_ob_wr, usr_ob_tlv
    );

endinterface

// File: rtl/cr_popcnt8.sv
// Combinational population count of an 8-bit vector.
//   din : input vector
//   cnt : number of set bits in din (0..8)
module cr_popcnt8 (
    input  logic [7:0] din,
    output logic [3:0] cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + 4'(din[i]);
        end
    end

endmodule

// File: rtl/cr_tlvp_usr_bytecnt.sv
// User-side stage between the TLV parser inbound and outbound FIFOs.
// Passes every word through one register stage, counts DATA payload bytes
// per frame and writes the count into the footer (FTR with eot) word.
//   clk, rst_n   : clock, asynchronous active-low reset
//   usr          : parser FIFO ports (slave side)
//   cnt_en       : 1 = patch footer count field, 0 = leave footer untouched
//   frame_done   : 1-cycle pulse after a footer eot word is popped
//   frame_bytes  : byte count of the last completed frame (held)
//   bytecnt_ovf  : sticky, set when the accumulator saturates
module cr_tlvp_usr_bytecnt
    import cr_structs::*;
    import cr_tlvp_usr_bytecnt_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int FTR_CNT_LSB = FTR_CNT_LSB_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cr_tlvp_usr_bytecnt_if.slave  usr,
    input  logic                  cnt_en,
    output logic                  frame_done,
    output logic [CNT_W-1:0]      frame_bytes,
    output logic                  bytecnt_ovf
);

    generate
        if (!bytecnt_params_ok(CNT_W, FTR_CNT_LSB)) begin : g_bad_params
            $error("cr_tlvp_usr_bytecnt: count field does not fit tdata[63:0]");
        end
    endgenerate

    // Sum is wide enough for acc plus a full 8-byte word, whatever CNT_W is.
    localparam int                SUM_W   = ((CNT_W > 4) ? CNT_W : 4) + 1;
    localparam logic [SUM_W-1:0]  ACC_MAX = SUM_W'({CNT_W{1'b1}});

    logic               out_vld;
    tlvp_if_bus_t       out_tlv;
    tlvp_if_bus_t       in_patched;
    logic               ib_en;
    logic [CNT_W-1:0]   acc;
    logic [CNT_W-1:0]   acc_nxt;
    logic [SUM_W-1:0]   acc_sum;
    logic [3:0]         strb_cnt;
    logic               ovf_set;
    logic               ftr_hit;
    logic               unused_ok;

    assign unused_ok = ^{usr.usr_ib_aempty, usr.usr_ob_afull};

    cr_popcnt8 u_popcnt (
        .din (usr.usr_ib_tlv.tstrb),
        .cnt (strb_cnt)
    );

    // ib_en keeps the read strobe low while in reset and for the first
    // cycle after it, without routing the async reset into the datapath.
    assign usr.usr_ob_wr  = out_vld & ~usr.usr_ob_full;
    assign usr.usr_ib_rd  = ib_en & ~usr.usr_ib_empty & (~out_vld | usr.usr_ob_wr);
    assign usr.usr_ob_tlv = out_tlv;

    assign acc_sum = SUM_W'(acc) + SUM_W'(strb_cnt);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        in_patched = usr.usr_ib_tlv;
        acc_nxt    = acc;
        ovf_set    = 1'b0;
        ftr_hit    = 1'b0;
        if (usr.usr_ib_tlv.typen == DATA) begin
            if (acc_sum > ACC_MAX) begin
                acc_nxt = '1;
                ovf_set = 1'b1;
            end else begin
                acc_nxt = acc_sum[CNT_W-1:0];
            end
        end else if (usr.usr_ib_tlv.typen == FTR && usr.usr_ib_tlv.eot) begin
            // Footer bytes are not counted; the next frame starts from zero.
            ftr_hit = 1'b1;
            acc_nxt = '0;
            if (cnt_en) begin
                in_patched.tdata[FTR_CNT_LSB +: CNT_W] = acc;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ib_en       <= 1'b0;
            out_vld     <= 1'b0;
            // NOTE: the output word register is reset too, so usr_ob_tlv is defined out of reset.
            out_tlv     <= '0;
            acc         <= '0;
            frame_done  <= 1'b0;
            frame_bytes <= '0;
            bytecnt_ovf <= 1'b0;
        end else begin
            ib_en      <= 1'b1;
            frame_done <= 1'b0;
            if (usr.usr_ib_rd) begin
                out_tlv <= in_patched;
                out_vld <= 1'b1;
                acc     <= acc_nxt;
                if (ftr_hit) begin
                    frame_done  <= 1'b1;
                    frame_bytes <= acc;
                end
                if (ovf_set) begin
                    bytecnt_ovf <= 1'b1;
                end
            end else if (usr.usr_ob_wr) begin
                out_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cr_tlvp_usr_bytecnt.sv
// Two instances share one inbound stream: "a" with the default 24-bit
// counter at bit 0, "b" with a 4-bit counter at bit 8 (saturates quickly).
module tb_cr_tlvp_usr_bytecnt;
    import cr_structs::*;

    localparam int W_A = 24, LSB_A = 0, W_B = 4, LSB_B = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         ib_empty, ob_full, cnt_en, gap;
    tlvp_if_bus_t ib_tlv;
    bit           rand_full, rand_gap, full_force, stall_seen;

    cr_tlvp_usr_bytecnt_if if_a ();
    cr_tlvp_usr_bytecnt_if if_b ();

    assign if_a.usr_ib_empty  = ib_empty;
    assign if_a.usr_ib_aempty = 1'b0;
    assign if_a.usr_ib_tlv    = ib_tlv;
    assign if_a.usr_ob_full   = ob_full;
    assign if_a.usr_ob_afull  = 1'b0;
    assign if_b.usr_ib_empty  = ib_empty;
    assign if_b.usr_ib_aempty = 1'b0;
    assign if_b.usr_ib_tlv    = ib_tlv;
    assign if_b.usr_ob_full   = ob_full;
    assign if_b.usr_ob_afull  = 1'b0;

    logic             fd_a, fd_b, ovf_a, ovf_b;
    logic [W_A-1:0]   fbytes_a;
    logic [W_B-1:0]   fbytes_b;

    cr_tlvp_usr_bytecnt #(.CNT_W(W_A), .FTR_CNT_LSB(LSB_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .usr(if_a), .cnt_en(cnt_en),
        .frame_done(fd_a), .frame_bytes(fbytes_a), .bytecnt_ovf(ovf_a));

    cr_tlvp_usr_bytecnt #(.CNT_W(W_B), .FTR_CNT_LSB(LSB_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .usr(if_b), .cnt_en(cnt_en),
        .frame_done(fd_b), .frame_bytes(fbytes_b), .bytecnt_ovf(ovf_b));

    logic         rd_s [2], wr_s [2], fd_s [2], ov_s [2];
    tlvp_if_bus_t ot_s [2];
    logic [23:0]  fb_s [2];
    assign rd_s[0] = if_a.usr_ib_rd;  assign rd_s[1] = if_b.usr_ib_rd;
    assign wr_s[0] = if_a.usr_ob_wr;  assign wr_s[1] = if_b.usr_ob_wr;
    assign ot_s[0] = if_a.usr_ob_tlv; assign ot_s[1] = if_b.usr_ob_tlv;
    assign fd_s[0] = fd_a;            assign fd_s[1] = fd_b;
    assign ov_s[0] = ovf_a;           assign ov_s[1] = ovf_b;
    assign fb_s[0] = fbytes_a;        assign fb_s[1] = {20'd0, fbytes_b};

    // Reference model state: source FIFO, expected outputs per instance.
    tlvp_if_bus_t      src_q [$];
    tlvp_if_bus_t      exp_q [2][$];
    longint unsigned   fb_q [2][$];
    bit                ov_q [2][$];
    longint unsigned   fsum [2];
    bit                ovf_m [2];
    logic [23:0]       fd_log_a [$];
    tlvp_if_bus_t      last_ob [2];
    tlvp_if_bus_t      held [2];
    bit                prev_rd [2];

    int checks = 0;
    int failures = 0;

    function automatic int wid(input int k);
        return (k == 0) ? W_A : W_B;
    endfunction

    function automatic int lsb(input int k);
        return (k == 0) ? LSB_A : LSB_B;
    endfunction

    function automatic string nm(input int k);
        return (k == 0) ? "a" : "b";
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic tlvp_if_bus_t mk(input tlv_types_e t, input logic eot,
                                        input logic [7:0] strb, input logic [63:0] data);
        tlvp_if_bus_t w;
        w       = '0;
        w.typen = t;
        w.eot   = eot;
        w.tstrb = strb;
        w.tdata = data;
        w.tid   = 8'($urandom);
        w.tuser = 8'($urandom);
        return w;
    endfunction

    // Frame byte total is the plain sum of strobe bits; the reported value
    // is that total clamped to the counter range, overflow if it exceeded it.
    task automatic push_word(input tlvp_if_bus_t w);
        tlvp_if_bus_t    e;
        longint unsigned maxv, bytes;
        src_q.push_back(w);
        for (int k = 0; k < 2; k++) begin
            e    = w;
            maxv = (64'd1 << wid(k)) - 1;
            if (w.typen == DATA) begin
                fsum[k] += $countones(w.tstrb);
            end else if (w.typen == FTR && w.eot) begin
                bytes = (fsum[k] > maxv) ? maxv : fsum[k];
                if (fsum[k] > maxv) ovf_m[k] = 1'b1;
                if (cnt_en) begin
                    for (int b = 0; b < wid(k); b++) e.tdata[lsb(k) + b] = bytes[b];
                end
                fb_q[k].push_back(bytes);
                ov_q[k].push_back(ovf_m[k]);
                fsum[k] = 0;
            end
            exp_q[k].push_back(e);
        end
    endtask

    task automatic drive_ib();
        ib_empty = (src_q.size() == 0) || gap;
        ib_tlv   = (src_q.size() != 0) ? src_q[0] : '0;
    endtask

    task automatic cycle();
        bit do_pop;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (prev_rd[k] && !ob_full)
                check({nm(k), "_latency"}, 128'(wr_s[k]), 128'(1'b1));
            if (wr_s[k]) begin
                last_ob[k] = ot_s[k];
                check({nm(k), "_word_expected"}, 128'(wr_s[k]), 128'(exp_q[k].size() != 0));
                if (exp_q[k].size() != 0)
                    check({nm(k), "_ob_word"}, 128'(ot_s[k]), 128'(exp_q[k].pop_front()));
            end
            if (fd_s[k]) begin
                if (k == 0) fd_log_a.push_back(fb_s[k]);
                check({nm(k), "_frame_expected"}, 128'(fd_s[k]), 128'(fb_q[k].size() != 0));
                if (fb_q[k].size() != 0) begin
                    check({nm(k), "_frame_bytes"}, 128'(fb_s[k]), 128'(fb_q[k].pop_front()));
                    check({nm(k), "_ovf"}, 128'(ov_s[k]), 128'(ov_q[k].pop_front()));
                end
            end
            if (full_force) begin
                check({nm(k), "_stall_rd"}, 128'(rd_s[k]), 128'(1'b0));
                check({nm(k), "_stall_wr"}, 128'(wr_s[k]), 128'(1'b0));
                if (stall_seen) check({nm(k), "_stall_hold"}, 128'(ot_s[k]), 128'(held[k]));
                held[k] = ot_s[k];
            end
            prev_rd[k] = rd_s[k];
        end
        stall_seen = full_force;
        check("rd_sync", 128'(rd_s[1]), 128'(rd_s[0]));
        do_pop = rd_s[0];
        @(posedge clk);
        #1;
        if (do_pop) void'(src_q.pop_front());
        ob_full = full_force | (rand_full && ($urandom_range(0, 3) == 0));
        gap     = rand_gap && ($urandom_range(0, 3) == 0);
        drive_ib();
    endtask

    task automatic drain(input int budget);
        int n;
        int pending;
        n = 0;
        drive_ib();
        pending = src_q.size() + exp_q[0].size() + exp_q[1].size() + fb_q[0].size() + fb_q[1].size();
        while (pending != 0 && n < budget) begin
            cycle();
            n++;
            pending = src_q.size() + exp_q[0].size() + exp_q[1].size() + fb_q[0].size() + fb_q[1].size();
        end
        check("drain_pending", 128'(pending), 128'(0));
    endtask

    // Called just after a posedge; optionally preloads one word so the
    // inbound FIFO is non-empty while reset is held.
    task automatic do_reset(input bit preload, input tlvp_if_bus_t pw);
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            fsum[k]    = 0;
            ovf_m[k]   = 1'b0;
            prev_rd[k] = 1'b0;
        end
        stall_seen = 1'b0;
        if (preload) push_word(pw);
        drive_ib();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check({nm(k), "_rst_rd"}, 128'(rd_s[k]), 128'(1'b0));
            check({nm(k), "_rst_wr"}, 128'(wr_s[k]), 128'(1'b0));
            check({nm(k), "_rst_tlv"}, 128'(ot_s[k]), 128'(0));
            check({nm(k), "_rst_done"}, 128'(fd_s[k]), 128'(1'b0));
            check({nm(k), "_rst_bytes"}, 128'(fb_s[k]), 128'(0));
            check({nm(k), "_rst_ovf"}, 128'(ov_s[k]), 128'(1'b0));
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic gen_frame();
        int n;
        int r;
        n = $urandom_range(0, 5);
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       push_word(mk(DATA, 1'b0, 8'($urandom), {$urandom, $urandom}));
            else if (r == 7) push_word(mk(CMD, 1'b0, 8'($urandom), {$urandom, $urandom}));
            else if (r == 8) push_word(mk(FTR, 1'b0, 8'($urandom), {$urandom, $urandom}));
            else             push_word(mk(PHD, 1'b1, 8'($urandom), {$urandom, $urandom}));
        end
        push_word(mk(FTR, 1'b1, 8'($urandom), {$urandom, $urandom}));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] ftr_data;
        rst_n = 1'b1; ob_full = 1'b0; cnt_en = 1'b1; gap = 1'b0;
        rand_full = 1'b0; rand_gap = 1'b0; full_force = 1'b0; stall_seen = 1'b0;
        ib_empty = 1'b1; ib_tlv = '0;
        #2;

        // Reset with a word waiting, then single frame FF,FF,0F + footer.
        do_reset(1'b1, mk(DATA, 1'b0, 8'hFF, 64'h1111_2222_3333_4444));
        push_word(mk(DATA, 1'b0, 8'hFF, 64'h5555_6666_7777_8888));
        push_word(mk(DATA, 1'b0, 8'h0F, 64'h9999_aaaa_bbbb_cccc));
        push_word(mk(FTR, 1'b1, 8'hFF, 64'h0));
        drain(100);
        check("single_bytes", 128'(fb_s[0]), 128'(20));
        check("single_ftr_a", 128'(last_ob[0].tdata[23:0]), 128'(24'h000014));
        check("single_ftr_b", 128'(last_ob[1].tdata[11:8]), 128'(4'hF));

        // Backpressure: 5-cycle stall with the pipeline full.
        push_word(mk(DATA, 1'b0, 8'h81, {$urandom, $urandom}));
        for (int i = 0; i < 5; i++) push_word(mk(DATA, 1'b0, 8'($urandom), {$urandom, $urandom}));
        push_word(mk(FTR, 1'b1, 8'h00, {$urandom, $urandom}));
        drive_ib();
        for (int i = 0; i < 3; i++) cycle();
        full_force = 1'b1;
        ob_full    = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        full_force = 1'b0;
        ob_full    = 1'b0;
        drain(100);

        // Back-to-back frames of 8, 0 and 1 bytes.
        fd_log_a.delete();
        push_word(mk(DATA, 1'b0, 8'hFF, {$urandom, $urandom}));
        push_word(mk(FTR, 1'b1, 8'h00, {$urandom, $urandom}));
        push_word(mk(FTR, 1'b1, 8'h00, {$urandom, $urandom}));
        push_word(mk(DATA, 1'b0, 8'h01, {$urandom, $urandom}));
        push_word(mk(FTR, 1'b1, 8'h00, {$urandom, $urandom}));
        drain(100);
        check("b2b_count", 128'(fd_log_a.size()), 128'(3));
        check("b2b_0", 128'(fd_log_a[0]), 128'(8));
        check("b2b_1", 128'(fd_log_a[1]), 128'(0));
        check("b2b_2", 128'(fd_log_a[2]), 128'(1));

        // Overflow on the 4-bit instance, then persistence into the next frame.
        do_reset(1'b0, '0);
        for (int i = 0; i < 3; i++) push_word(mk(DATA, 1'b0, 8'hFF, {$urandom, $urandom}));
        push_word(mk(FTR, 1'b1, 8'h00, 64'h0));
        drain(100);
        check("ovf_set_b", 128'(ov_s[1]), 128'(1'b1));
        check("ovf_bytes_b", 128'(fb_s[1]), 128'(15));
        check("ovf_ftr_b", 128'(last_ob[1].tdata), 128'(64'h0000_0000_0000_0F00));
        push_word(mk(DATA, 1'b0, 8'h01, {$urandom, $urandom}));
        push_word(mk(FTR, 1'b1, 8'h00, {$urandom, $urandom}));
        drain(100);
        check("ovf_sticky_b", 128'(ov_s[1]), 128'(1'b1));
        check("ovf_next_bytes_b", 128'(fb_s[1]), 128'(1));
        check("ovf_clear_a", 128'(ov_s[0]), 128'(1'b0));

        // cnt_en=0 and reset after two DATA words.
        cnt_en = 1'b0;
        push_word(mk(DATA, 1'b0, 8'hFF, {$urandom, $urandom}));
        push_word(mk(DATA, 1'b0, 8'hFF, {$urandom, $urandom}));
        drain(100);
        do_reset(1'b0, '0);
        ftr_data = {$urandom, $urandom};
        push_word(mk(DATA, 1'b0, 8'h0F, {$urandom, $urandom}));
        push_word(mk(FTR, 1'b1, 8'h00, ftr_data));
        drain(100);
        check("nocnt_bytes", 128'(fb_s[0]), 128'(4));
        check("nocnt_ftr", 128'(last_ob[0].tdata), 128'(ftr_data));

        // Randomized frames with random gaps and backpressure.
        rand_full = 1'b1;
        rand_gap  = 1'b1;
        for (int batch = 0; batch < 4; batch++) begin
            cnt_en = (batch % 2 == 0);
            for (int f = 0; f < 25; f++) gen_frame();
            drain(3000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
